hazard_control: RTL

- Central pipeline control block. Generates the stall, bubble and flush signals consumed by the IF/ID and ID/EX pipeline latches.
- Detects load-use hazards between ID and EX.
- Holds the pipeline for multi-cycle FPU operations occupying EX.
- Squashes younger instructions when a branch or jump resolves taken in EX.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_control.sv | 96 +++++++++
 1 files changed

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stall, FPU multi-cycle hold and taken-branch
// squash for the IF/ID and ID/EX latches, plus saturating stall/flush event counters.
module hazard_control #(
  parameter int FPU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       IDRegAAddr,
  input  logic [5:0]       IDRegBAddr,
  input  logic             IDUsesA,
  input  logic             IDUsesB,
  input  logic             EXMemRead,
  input  logic             EXRegWE,
  input  logic [5:0]       EXRegWBAddr,
  input  logic             EXFPUStart,
  input  logic             EXBranchTaken,
  output logic             stall,
  output logic             BubbleEX,
  output logic             FlushID,
  output logic             FPUDone,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {IDLE, FPU_BUSY} state_t;

  // The start cycle and the done cycle are not counted down, hence the -2.
  localparam logic [3:0] FPU_LOAD = 4'(FPU_LATENCY - 2);

  state_t     state, state_next;
  logic [3:0] fpu_cnt, fpu_cnt_next;
  logic       load_use;

  assign load_use = EXMemRead && EXRegWE && (EXRegWBAddr != 6'd0) &&
                    ((IDUsesA && (IDRegAAddr == EXRegWBAddr)) ||
                     (IDUsesB && (IDRegBAddr == EXRegWBAddr)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      fpu_cnt <= 4'd0;
    end else begin
      state   <= state_next;
      fpu_cnt <= fpu_cnt_next;
    end
  end

  // Priority in IDLE: FPU start, then taken branch (squashes the dependent op), then load-use.
  always_comb begin
    stall        = 1'b0;
    BubbleEX     = 1'b0;
    FlushID      = 1'b0;
    FPUDone      = 1'b0;
    state_next   = state;
    fpu_cnt_next = fpu_cnt;
    case (state)
      IDLE: begin
        if (EXFPUStart) begin
          stall        = 1'b1;
          fpu_cnt_next = FPU_LOAD;
          state_next   = FPU_BUSY;
        end else if (EXBranchTaken) begin
          FlushID  = 1'b1;
          BubbleEX = 1'b1;
        end else if (load_use) begin
          stall    = 1'b1;
          BubbleEX = 1'b1;
        end
      end
      FPU_BUSY: begin
        if (fpu_cnt != 4'd0) begin
          stall        = 1'b1;
          fpu_cnt_next = fpu_cnt - 4'd1;
        end else begin
          FPUDone    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stall && (StallCount != {CNT_W{1'b1}}))
        StallCount <= StallCount + 1'b1;
      if (FlushID && (FlushCount != {CNT_W{1'b1}}))
        FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule
